pc_next_gen: RTL and testbench

//   Produces next_pc for the 13-bit program counter register every cycle: sequential, branch, jump, call, return.

---
 rtl/pc_next_gen.sv | 106 ++++++++++
 tb/tb_pc_next_gen.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/pc_next_gen.sv
// Next-PC selection for the 13-bit program counter: sequential, branch, jump, call and return,
// with a circular return-address stack and a registered one-cycle flush after taken redirects.
module pc_next_gen #(
    parameter int PC_W      = 13,
    parameter int OFF_W     = 8,
    parameter int RAS_DEPTH = 4,
    parameter int RAS_AW    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [PC_W-1:0]   curr_pc,
    input  logic              stall,
    input  logic              br_taken,
    input  logic [OFF_W-1:0]  br_offset,
    input  logic              jmp,
    input  logic              call,
    input  logic              ret,
    input  logic [PC_W-1:0]   jmp_target,
    output logic [PC_W-1:0]   next_pc,
    output logic              flush,
    output logic              ras_ovf,
    output logic              ras_unf
);

    logic [PC_W-1:0]   ras [RAS_DEPTH];
    logic [RAS_AW-1:0] ras_ptr;
    logic [RAS_AW:0]   ras_cnt;

    logic [PC_W-1:0]   seq_pc;
    logic [PC_W-1:0]   br_pc;
    logic              ras_empty;
    logic              ras_full;
    logic              redirect;
    logic              do_pop;
    logic              do_push;
    logic              unf_hit;

    assign seq_pc    = curr_pc + PC_W'(1);
    assign br_pc     = seq_pc + {{(PC_W-OFF_W){br_offset[OFF_W-1]}}, br_offset};
    assign ras_empty = (ras_cnt == '0);
    assign ras_full  = (ras_cnt == (RAS_AW+1)'(RAS_DEPTH));

    // ras_ptr always addresses the most recent entry; a push writes one slot above it.
    always_comb begin
        next_pc  = seq_pc;
        redirect = 1'b0;
        do_pop   = 1'b0;
        do_push  = 1'b0;
        unf_hit  = 1'b0;
        if (rst) begin
            next_pc = '0;
        end else if (stall) begin
            next_pc = curr_pc;
        end else if (ret) begin
            if (!ras_empty) begin
                next_pc  = ras[ras_ptr];
                do_pop   = 1'b1;
                redirect = 1'b1;
            end else begin
                unf_hit  = 1'b1;
            end
        end else if (call) begin
            next_pc  = jmp_target;
            do_push  = 1'b1;
            redirect = 1'b1;
        end else if (jmp) begin
            next_pc  = jmp_target;
            redirect = 1'b1;
        end else if (br_taken) begin
            next_pc  = br_pc;
            redirect = 1'b1;
        end
    end

    // A push into a full stack overwrites the oldest entry, so the count saturates.
    always_ff @(posedge clk) begin
        if (rst) begin
            ras_ptr <= '0;
            ras_cnt <= '0;
            flush   <= 1'b0;
            ras_ovf <= 1'b0;
            ras_unf <= 1'b0;
        end else begin
            flush <= redirect;
            if (do_pop) begin
                ras_ptr <= ras_ptr - RAS_AW'(1);
                ras_cnt <= ras_cnt - (RAS_AW+1)'(1);
            end
            if (do_push) begin
                ras_ptr <= ras_ptr + RAS_AW'(1);
                if (ras_full)
                    ras_ovf <= 1'b1;
                else
                    ras_cnt <= ras_cnt + (RAS_AW+1)'(1);
            end
            if (unf_hit)
                ras_unf <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && do_push)
            ras[ras_ptr + RAS_AW'(1)] <= seq_pc;
    end

endmodule

// File: tb/tb_pc_next_gen.sv
// Randomized and directed bench for pc_next_gen; expectations come from a queue-based
// reference model and are checked by a separate negedge monitor.
module tb_pc_next_gen;

    localparam int PC_W  = 13;
    localparam int OFF_W = 8;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [PC_W-1:0]  curr_pc;
    logic             stall;
    logic             br_taken;
    logic [OFF_W-1:0] br_offset;
    logic             jmp;
    logic             call;
    logic             ret;
    logic [PC_W-1:0]  jmp_target;
    logic [PC_W-1:0]  next_pc;
    logic             flush;
    logic             ras_ovf;
    logic             ras_unf;

    pc_next_gen dut (
        .clk(clk), .rst(rst), .curr_pc(curr_pc), .stall(stall),
        .br_taken(br_taken), .br_offset(br_offset), .jmp(jmp), .call(call),
        .ret(ret), .jmp_target(jmp_target), .next_pc(next_pc), .flush(flush),
        .ras_ovf(ras_ovf), .ras_unf(ras_unf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [PC_W-1:0] pc;
        logic            fl;
        logic            ovf;
        logic            unf;
        bit              chk_flags;
    } exp_t;

    exp_t            sb[$];
    logic [PC_W-1:0] ras_model[$];
    bit              m_flush, m_ovf, m_unf, m_known;
    int              checks   = 0;
    int              failures = 0;

    task automatic checkOutput(input string name, input logic [PC_W-1:0] act, input logic [PC_W-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, req);
        end
    endtask

    // Expectations are computed from the model state before the edge, then the model advances.
    task automatic applyStimulus(input logic r, input logic s, input logic bt, input logic [OFF_W-1:0] off,
                                 input logic j, input logic c, input logic rt,
                                 input logic [PC_W-1:0] tgt, input logic [PC_W-1:0] cpc);
        exp_t            e;
        logic [PC_W-1:0] seq, brt;
        bit              red;
        rst = r; stall = s; br_taken = bt; br_offset = off; jmp = j;
        call = c; ret = rt; jmp_target = tgt; curr_pc = cpc;
        seq = PC_W'((int'(cpc) + 1) % 8192);
        brt = PC_W'((int'(cpc) + 1 + int'($signed(off)) + 8192) % 8192);
        e.fl = m_flush; e.ovf = m_ovf; e.unf = m_unf; e.chk_flags = m_known;
        red = 0;
        if (r)                     e.pc = '0;
        else if (s)                e.pc = cpc;
        else if (rt && ras_model.size() > 0) begin e.pc = ras_model[$]; red = 1; end
        else if (rt)               e.pc = seq;
        else if (c || j)           begin e.pc = tgt; red = 1; end
        else if (bt)               begin e.pc = brt; red = 1; end
        else                       e.pc = seq;
        sb.push_back(e);
        @(posedge clk);
        if (r) begin
            ras_model.delete();
            m_flush = 0; m_ovf = 0; m_unf = 0; m_known = 1;
        end else begin
            m_flush = red;
            if (!s && rt) begin
                if (ras_model.size() > 0) void'(ras_model.pop_back());
                else m_unf = 1;
            end else if (!s && c) begin
                if (ras_model.size() == DEPTH) begin
                    void'(ras_model.pop_front());
                    m_ovf = 1;
                end
                ras_model.push_back(seq);
            end
        end
        #1;
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            checkOutput("next_pc", next_pc, e.pc);
            if (e.chk_flags) begin
                checkOutput("flush", PC_W'(flush), PC_W'(e.fl));
                checkOutput("ras_ovf", PC_W'(ras_ovf), PC_W'(e.ovf));
                checkOutput("ras_unf", PC_W'(ras_unf), PC_W'(e.unf));
            end
        end
    end

    initial begin
        @(posedge clk);
        #1;
        // reset and sequential wrap
        applyStimulus(1, 0, 0, 8'd0, 0, 0, 0, 13'd0, 13'h0AB);
        applyStimulus(1, 0, 0, 8'd0, 0, 0, 0, 13'd0, 13'h0AB);
        applyStimulus(0, 0, 0, 8'd0, 0, 0, 0, 13'd0, 13'h1FFF);
        applyStimulus(0, 0, 0, 8'd0, 0, 0, 0, 13'd0, 13'd7);
        // branch back by 5, then flush for exactly one cycle
        applyStimulus(0, 0, 1, 8'hFB, 0, 0, 0, 13'd0, 13'd100);
        applyStimulus(0, 0, 0, 8'd0, 0, 0, 0, 13'd0, 13'd96);
        applyStimulus(0, 0, 0, 8'd0, 0, 0, 0, 13'd0, 13'd97);
        // call then two returns, the second underflowing
        applyStimulus(0, 0, 0, 8'd0, 0, 1, 0, 13'd200, 13'd10);
        applyStimulus(0, 0, 0, 8'd0, 0, 0, 1, 13'd0, 13'd205);
        applyStimulus(0, 0, 0, 8'd0, 0, 0, 1, 13'd0, 13'd205);
        applyStimulus(0, 0, 0, 8'd0, 0, 0, 0, 13'd0, 13'd206);
        // overflow with five calls, then drain with five returns
        applyStimulus(1, 0, 0, 8'd0, 0, 0, 0, 13'd0, 13'd0);
        for (int i = 1; i <= 5; i++)
            applyStimulus(0, 0, 0, 8'd0, 0, 1, 0, 13'd300, 13'(i));
        for (int i = 0; i < 5; i++)
            applyStimulus(0, 0, 0, 8'd0, 0, 0, 1, 13'd0, 13'd400);
        applyStimulus(0, 0, 0, 8'd0, 0, 0, 0, 13'd0, 13'd401);
        // stall blocks a call; call+ret gives the return
        applyStimulus(1, 0, 0, 8'd0, 0, 0, 0, 13'd0, 13'd0);
        applyStimulus(0, 0, 0, 8'd0, 0, 1, 0, 13'd40, 13'd6);
        applyStimulus(0, 1, 0, 8'd0, 0, 1, 0, 13'd99, 13'd50);
        applyStimulus(0, 0, 0, 8'd0, 0, 1, 1, 13'd99, 13'd60);
        applyStimulus(0, 0, 0, 8'd0, 0, 0, 1, 13'd0, 13'd8);
        applyStimulus(0, 0, 1, 8'd3, 1, 0, 0, 13'd1234, 13'd20);
        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            applyStimulus(($urandom_range(0, 59) == 0), ($urandom_range(0, 7) == 0),
                          ($urandom_range(0, 3) == 0), OFF_W'($urandom),
                          ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0),
                          ($urandom_range(0, 3) == 0), PC_W'($urandom), PC_W'($urandom));
        end
        applyStimulus(0, 0, 0, 8'd0, 0, 0, 0, 13'd0, 13'd0);
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() > 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL drain: %0d expectations left, expected 0", sb.size());
        end
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
